regfile_sb: RTL and testbench



---
 rtl/regfile_sb.sv | 108 ++++++++++
 tb/tb_regfile_sb.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Integer register file (2 async read ports, 1 sync write port) with an issue scoreboard.
// Optional write-through bypass on the read ports: define REGFILE_SB_BYPASS_EN.
module regfile_sb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = $clog2(NREGS),
    localparam int unsigned CW      = $clog2(NREGS) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    input  logic [AW-1:0]   A3,
    input  logic            WE3,
    input  logic [XLEN-1:0] WD3,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_rd,
    output logic            busy1,
    output logic            busy2,
    output logic [CW-1:0]   pend_cnt,
    output logic            sb_full
);

    logic [XLEN-1:0]  rf_q [NREGS];
    logic [NREGS-1:0] pend_q, pend_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             we_v, iss_v, set_eff, clr_eff;

    // Write and issue qualified by reset and by the hardwired zero register.
    always_comb begin
        we_v    = rst_n && WE3 && !((ZERO_REG != 0) && (A3 == '0));
        iss_v   = rst_n && iss_en && !((ZERO_REG != 0) && (iss_rd == '0));
        set_eff = iss_v && !pend_q[iss_rd];
        // A clear loses to a same-cycle set on the same register.
        clr_eff = we_v && pend_q[A3] && !(iss_v && (iss_rd == A3));
    end

    always_comb begin
        pend_d = pend_q;
        if (we_v) begin
            pend_d[A3] = 1'b0;
        end
        if (iss_v) begin
            pend_d[iss_rd] = 1'b1;
        end
        cnt_d  = cnt_q + CW'(set_eff) - CW'(clr_eff);
        full_d = (cnt_d == CW'(NREGS - ZERO_REG));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                rf_q[i] <= '0;
            end
        end else if (we_v) begin
            rf_q[A3] <= WD3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    always_comb begin
        RD1   = rf_q[A1];
        RD2   = rf_q[A2];
        busy1 = pend_q[A1];
        busy2 = pend_q[A2];
        if ((ZERO_REG != 0) && (A1 == '0)) begin
            RD1 = '0;
        end
        if ((ZERO_REG != 0) && (A2 == '0)) begin
            RD2 = '0;
        end
`ifdef REGFILE_SB_BYPASS_EN
        // Writeback forwards to a same-cycle reader and retires its busy bit,
        // unless a new producer for that register issues in the same cycle.
        if (we_v && (A3 == A1)) begin
            RD1 = WD3;
            if (!(iss_v && (iss_rd == A1))) begin
                busy1 = 1'b0;
            end
        end
        if (we_v && (A3 == A2)) begin
            RD2 = WD3;
            if (!(iss_v && (iss_rd == A2))) begin
                busy2 = 1'b0;
            end
        end
`endif
    end

    assign pend_cnt = cnt_q;
    assign sb_full  = full_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus random traffic
// compared against an array-based reference model.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  A1 = '0, A2 = '0, A3 = '0, iss_rd = '0;
    logic        WE3 = 1'b0, iss_en = 1'b0;
    logic [31:0] WD3 = '0;
    logic [31:0] RD1, RD2;
    logic        busy1, busy2, sb_full;
    logic [5:0]  pend_cnt;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_mem [32];
    bit          m_pend [32];

    regfile_sb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A1       (A1),
        .A2       (A2),
        .RD1      (RD1),
        .RD2      (RD2),
        .A3       (A3),
        .WE3      (WE3),
        .WD3      (WD3),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .busy1    (busy1),
        .busy2    (busy2),
        .pend_cnt (pend_cnt),
        .sb_full  (sb_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endfunction

    function automatic int exp_cnt();
        int c = 0;
        for (int i = 0; i < 32; i++) begin
            if (m_pend[i]) c++;
        end
        return c;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
`ifdef REGFILE_SB_BYPASS_EN
        if (rst_n && WE3 && A3 != 0 && A3 == a) return WD3;
`endif
        if (a == 0) return '0;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
`ifdef REGFILE_SB_BYPASS_EN
        if (rst_n && WE3 && A3 != 0 && A3 == a && !(iss_en && iss_rd == a)) return 1'b0;
`endif
        return m_pend[a];
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".rd1"}, RD1, exp_rd(A1));
        check({tag, ".rd2"}, RD2, exp_rd(A2));
        check({tag, ".busy1"}, 32'(busy1), 32'(exp_busy(A1)));
        check({tag, ".busy2"}, 32'(busy2), 32'(exp_busy(A2)));
        check({tag, ".cnt"}, 32'(pend_cnt), 32'(exp_cnt()));
        check({tag, ".full"}, 32'(sb_full), 32'(exp_cnt() == 31));
    endtask

    // Drive one cycle of inputs, check combinational view, clock, update model.
    task automatic tick(input string tag, input logic we, input logic [4:0] a3,
                        input logic [31:0] wd, input logic iss, input logic [4:0] rd,
                        input logic [4:0] a1, input logic [4:0] a2);
        WE3 = we; A3 = a3; WD3 = wd; iss_en = iss; iss_rd = rd; A1 = a1; A2 = a2;
        #1;
        check_all(tag);
        @(posedge clk);
        if (rst_n) begin
            if (we && a3 != 0) begin
                m_mem[a3]  = wd;
                m_pend[a3] = 1'b0;
            end
            if (iss && rd != 0) m_pend[rd] = 1'b1;
        end
        #1;
        WE3 = 1'b0; iss_en = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        check_all("reset");
        #5 rst_n = 1'b1;
        @(posedge clk); #1;

        tick("wr7", 1, 7, 32'h12345678, 0, 0, 7, 7);
        tick("rd7", 0, 0, 0, 0, 0, 7, 7);
        check("rd7.rd1.const", RD1, 32'h12345678);
        tick("wr0", 1, 0, 32'hFFFFFFFF, 0, 0, 0, 7);
        tick("rd0", 0, 0, 0, 0, 0, 0, 0);
        check("rd0.const", RD1, 32'h0);

        tick("iss3", 0, 0, 0, 1, 3, 3, 4);
        tick("iss4", 0, 0, 0, 1, 4, 3, 4);
        check("sb.cnt2", 32'(pend_cnt), 32'd2);
        check("sb.busy3", 32'(busy1), 32'd1);
        tick("wb3", 1, 3, 32'h33, 0, 0, 3, 4);
        tick("aft_wb3", 0, 0, 0, 0, 0, 3, 4);
        check("sb.cnt1", 32'(pend_cnt), 32'd1);
        check("sb.busy3_clr", 32'(busy1), 32'd0);

        tick("iss9", 0, 0, 0, 1, 9, 9, 0);
        tick("sim9", 1, 9, 32'h99, 1, 9, 9, 0);
        tick("aft_sim9", 0, 0, 0, 0, 0, 9, 0);
        check("sim.busy9", 32'(busy1), 32'd1);
        check("sim.cnt", 32'(pend_cnt), 32'd2);

        tick("wr10", 1, 10, 32'h11110000, 0, 0, 10, 0);
        tick("iss10", 0, 0, 0, 1, 10, 10, 0);
        WE3 = 1'b1; A3 = 5'd10; WD3 = 32'hA5A5A5A5; A1 = 5'd10;
        #1;
`ifdef REGFILE_SB_BYPASS_EN
        check("byp.rd1", RD1, 32'hA5A5A5A5);
        check("byp.busy1", 32'(busy1), 32'd0);
`else
        check("nobyp.rd1", RD1, 32'h11110000);
        check("nobyp.busy1", 32'(busy1), 32'd1);
`endif
        tick("wb10", 1, 10, 32'hA5A5A5A5, 0, 0, 10, 9);

        for (int r = 1; r < 32; r++) begin
            tick("fill", 0, 0, 0, 1, 5'(r), 5'(r), 5'(32 - r));
        end
        check("full.cnt", 32'(pend_cnt), 32'd31);
        check("full.flag", 32'(sb_full), 32'd1);
        tick("iss_r0", 0, 0, 0, 1, 0, 0, 1);
        check("full.r0_cnt", 32'(pend_cnt), 32'd31);
        tick("wb1", 1, 1, 32'h1, 0, 0, 1, 2);
        check("unfull.flag", 32'(sb_full), 32'd0);
        check("unfull.cnt", 32'(pend_cnt), 32'd30);

        for (int n = 0; n < 300; n++) begin
            tick("rand", 1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 5'($urandom));
        end

        tick("wr5", 1, 5, 32'hDEADBEEF, 1, 6, 5, 6);
        A1 = 5'd5; A2 = 5'd6;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("arst.rd1", RD1, 32'h0);
        check("arst.cnt", 32'(pend_cnt), 32'd0);
        check("arst.busy1", 32'(busy1), 32'd0);
        tick("in_rst", 1, 5, 32'h55, 1, 5, 5, 6);
        #3 rst_n = 1'b1;
        tick("post_rst", 0, 0, 0, 0, 0, 5, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
